// File: rtl/pipe_hazard_sched.sv
// Hazard scheduler for a 5-stage MIPS pipeline: one-cycle load-use stalls and
// a counted fetch block after branches/jumps, with saturating statistics.
module pipe_hazard_sched #(
  parameter int BR_BUBBLES = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic [5:0]       op_d,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             stall_data_n,
  output logic             stall_ctrl_n,
  output logic             busy,
  output logic [CNT_W-1:0] data_stalls,
  output logic [CNT_W-1:0] ctrl_bubbles
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    LU_STALL  = 2'd1,
    CTRL_WAIT = 2'd2
  } state_t;

  // The branch cycle itself is the first bubble, CTRL_WAIT supplies the rest.
  localparam logic [2:0] CNT_INIT = 3'((BR_BUBBLES > 1) ? (BR_BUBBLES - 2) : 0);

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0] r_data_stalls, r_ctrl_bubbles;
  logic             w_inc_data, w_inc_ctrl;
  logic             w_br_d, w_uses_rt, w_lu_hz;

  assign w_br_d    = (op_d == 6'b000100) || (op_d == 6'b000101) ||
                     (op_d == 6'b000010) || (op_d == 6'b000011);
  assign w_uses_rt = (op_d == 6'b000000) || (op_d == 6'b000100) ||
                     (op_d == 6'b000101) || (op_d == 6'b101011);
  assign w_lu_hz   = ex_memread && (ex_rt != 5'd0) &&
                     ((ex_rt == rs_d) || (w_uses_rt && (ex_rt == rt_d)));

  // State register: state, bubble counter and statistics.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= RUN;
      r_cnt          <= 3'd0;
      r_data_stalls  <= '0;
      r_ctrl_bubbles <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_inc_data && (r_data_stalls != '1))
        r_data_stalls <= r_data_stalls + 1'b1;
      if (w_inc_ctrl && (r_ctrl_bubbles != '1))
        r_ctrl_bubbles <= r_ctrl_bubbles + 1'b1;
    end
  end

  // Next-state logic; LU_STALL re-evaluates hazards exactly like RUN.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_inc_data  = 1'b0;
    w_inc_ctrl  = 1'b0;
    if (!freeze) begin
      case (r_state)
        RUN, LU_STALL: begin
          if (w_lu_hz) begin
            w_state_nxt = LU_STALL;
            w_inc_data  = 1'b1;
          end else if (w_br_d) begin
            w_inc_ctrl = 1'b1;
            if (BR_BUBBLES == 1) begin
              w_state_nxt = RUN;
            end else begin
              w_state_nxt = CTRL_WAIT;
              w_cnt_nxt   = CNT_INIT;
            end
          end else begin
            w_state_nxt = RUN;
          end
        end
        CTRL_WAIT: begin
          w_inc_ctrl = 1'b1;
          if (r_cnt != 3'd0) w_cnt_nxt = r_cnt - 3'd1;
          else               w_state_nxt = RUN;
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  // Output logic. Reset gates the decode so a held reset forces safe enables
  // even while hazard-looking inputs are present.
  always_comb begin
    pc_we        = 1'b1;
    if_id_we     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    stall_data_n = 1'b1;
    stall_ctrl_n = 1'b1;
    if (!reset) begin
      pc_we = 1'b1;
    end else if (freeze) begin
      pc_we    = 1'b0;
      if_id_we = 1'b0;
    end else begin
      case (r_state)
        RUN, LU_STALL: begin
          if (w_lu_hz) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_flush  = 1'b1;
            stall_data_n = 1'b0;
          end else if (w_br_d) begin
            pc_we        = (BR_BUBBLES == 1);
            if_id_flush  = 1'b1;
            stall_ctrl_n = 1'b0;
          end
        end
        CTRL_WAIT: begin
          pc_we        = (r_cnt == 3'd0);
          if_id_flush  = 1'b1;
          stall_ctrl_n = 1'b0;
        end
        default: pc_we = 1'b1;
      endcase
    end
  end

  assign busy         = (r_state != RUN);
  assign data_stalls  = r_data_stalls;
  assign ctrl_bubbles = r_ctrl_bubbles;

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Scoreboard bench for pipe_hazard_sched: a bubble-count reference model pushes
// expected per-cycle responses; a negedge monitor pops and compares them.
module tb_pipe_hazard_sched;

  localparam int BRB = 3;

  logic       clk, reset, freeze, ex_memread;
  logic [5:0] op_d;
  logic [4:0] rs_d, rt_d, ex_rt;

  logic        pc_we, if_id_we, if_id_flush, id_ex_flush;
  logic        stall_data_n, stall_ctrl_n, busy;
  logic [15:0] data_stalls, ctrl_bubbles;

  logic        s_pc_we, s_if_id_we, s_if_id_flush, s_id_ex_flush;
  logic        s_stall_data_n, s_stall_ctrl_n, s_busy;
  logic [1:0]  s_data_stalls, s_ctrl_bubbles;

  pipe_hazard_sched #(.BR_BUBBLES(BRB), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .freeze(freeze), .op_d(op_d), .rs_d(rs_d),
    .rt_d(rt_d), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .stall_data_n(stall_data_n),
    .stall_ctrl_n(stall_ctrl_n), .busy(busy),
    .data_stalls(data_stalls), .ctrl_bubbles(ctrl_bubbles)
  );

  pipe_hazard_sched #(.BR_BUBBLES(BRB), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .freeze(freeze), .op_d(op_d), .rs_d(rs_d),
    .rt_d(rt_d), .ex_memread(ex_memread), .ex_rt(ex_rt),
    .pc_we(s_pc_we), .if_id_we(s_if_id_we), .if_id_flush(s_if_id_flush),
    .id_ex_flush(s_id_ex_flush), .stall_data_n(s_stall_data_n),
    .stall_ctrl_n(s_stall_ctrl_n), .busy(s_busy),
    .data_stalls(s_data_stalls), .ctrl_bubbles(s_ctrl_bubbles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pc_we, if_id_we, if_id_flush, id_ex_flush;
    logic        stall_data_n, stall_ctrl_n, busy;
    logic [15:0] ds, cb;
    logic [1:0]  ds2, cb2;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: pending control bubbles, a "just stalled" flag and
  // unbounded event counts (clipped to counter width only when compared).
  int m_wait = 0, m_after_lu = 0, m_ds = 0, m_cb = 0;

  localparam logic [5:0] OP_R = 6'b000000, OP_BEQ = 6'b000100, OP_BNE = 6'b000101;
  localparam logic [5:0] OP_J = 6'b000010, OP_JAL = 6'b000011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_LW = 6'b100011, OP_ADDI = 6'b001000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [15:0] clip16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic logic [1:0] clip2(input int v);
    return (v > 3) ? 2'd3 : 2'(v);
  endfunction

  task automatic step(input logic rst, input logic frz, input logic [5:0] op,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic mr, input logic [4:0] ert);
    exp_t e;
    int n_wait, n_after_lu, n_ds, n_cb;
    logic br, urt, lu;
    reset = rst; freeze = frz; op_d = op; rs_d = rs; rt_d = rt;
    ex_memread = mr; ex_rt = ert;

    br  = op inside {OP_BEQ, OP_BNE, OP_J, OP_JAL};
    urt = op inside {OP_R, OP_BEQ, OP_BNE, OP_SW};
    lu  = mr && (ert != 0) && ((ert == rs) || (urt && (ert == rt)));

    if (!rst) begin
      m_wait = 0; m_after_lu = 0; m_ds = 0; m_cb = 0;
    end
    n_wait = m_wait; n_after_lu = m_after_lu; n_ds = m_ds; n_cb = m_cb;

    e.pc_we = 1; e.if_id_we = 1; e.if_id_flush = 0; e.id_ex_flush = 0;
    e.stall_data_n = 1; e.stall_ctrl_n = 1;
    e.busy = (m_wait > 0) || (m_after_lu != 0);
    e.ds = clip16(m_ds); e.cb = clip16(m_cb);
    e.ds2 = clip2(m_ds); e.cb2 = clip2(m_cb);

    if (!rst) begin
      e.busy = 0;
    end else if (frz) begin
      e.pc_we = 0; e.if_id_we = 0;
    end else if (m_wait > 0) begin
      e.if_id_flush = 1; e.stall_ctrl_n = 0;
      e.pc_we = (m_wait == 1);
      n_cb = m_cb + 1; n_wait = m_wait - 1;
    end else if (lu) begin
      e.pc_we = 0; e.if_id_we = 0; e.id_ex_flush = 1; e.stall_data_n = 0;
      n_ds = m_ds + 1; n_after_lu = 1;
    end else if (br) begin
      e.pc_we = (BRB == 1); e.if_id_flush = 1; e.stall_ctrl_n = 0;
      n_cb = m_cb + 1; n_wait = BRB - 1; n_after_lu = 0;
    end else begin
      n_after_lu = 0;
    end

    q.push_back(e);
    @(posedge clk);
    m_wait = n_wait; m_after_lu = n_after_lu; m_ds = n_ds; m_cb = n_cb;
    #1;
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) step(1, 0, OP_ADDI, 5'd0, 5'd0, 0, 5'd0);
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("pc_we",         {31'd0, pc_we},          {31'd0, mon_e.pc_we});
      check("if_id_we",      {31'd0, if_id_we},       {31'd0, mon_e.if_id_we});
      check("if_id_flush",   {31'd0, if_id_flush},    {31'd0, mon_e.if_id_flush});
      check("id_ex_flush",   {31'd0, id_ex_flush},    {31'd0, mon_e.id_ex_flush});
      check("stall_data_n",  {31'd0, stall_data_n},   {31'd0, mon_e.stall_data_n});
      check("stall_ctrl_n",  {31'd0, stall_ctrl_n},   {31'd0, mon_e.stall_ctrl_n});
      check("busy",          {31'd0, busy},           {31'd0, mon_e.busy});
      check("data_stalls",   {16'd0, data_stalls},    {16'd0, mon_e.ds});
      check("ctrl_bubbles",  {16'd0, ctrl_bubbles},   {16'd0, mon_e.cb});
      check("sat_data",      {30'd0, s_data_stalls},  {30'd0, mon_e.ds2});
      check("sat_ctrl",      {30'd0, s_ctrl_bubbles}, {30'd0, mon_e.cb2});
      check("sat_pc_we",     {31'd0, s_pc_we},        {31'd0, mon_e.pc_we});
    end
  end

  initial begin
    logic [5:0] ops [8];
    ops = '{OP_R, OP_BEQ, OP_BNE, OP_J, OP_JAL, OP_SW, OP_LW, OP_ADDI};
    reset = 0; freeze = 0; op_d = OP_BEQ; rs_d = 0; rt_d = 0;
    ex_memread = 1; ex_rt = 5'd8;
    @(posedge clk); #1;

    // Held reset with hazard-looking inputs, then release
    step(0, 0, OP_BEQ, 5'd8, 5'd8, 1, 5'd8);
    step(0, 0, OP_BEQ, 5'd8, 5'd8, 1, 5'd8);
    nop(1);

    // Load-use on rt, then the ex_rt==0 case
    step(1, 0, OP_R, 5'd1, 5'd8, 1, 5'd8);
    nop(1);
    step(1, 0, OP_R, 5'd0, 5'd0, 1, 5'd0);
    nop(1);

    // Branch: three bubbles
    step(1, 0, OP_BNE, 5'd1, 5'd2, 0, 5'd0);
    nop(3);

    // Load-use colliding with a branch in ID
    step(1, 0, OP_BEQ, 5'd5, 5'd6, 1, 5'd5);
    step(1, 0, OP_BEQ, 5'd5, 5'd6, 0, 5'd0);
    nop(3);

    // Freeze for two cycles inside the control wait
    step(1, 0, OP_J, 5'd0, 5'd0, 0, 5'd0);
    step(1, 1, OP_ADDI, 5'd0, 5'd0, 0, 5'd0);
    step(1, 1, OP_ADDI, 5'd0, 5'd0, 0, 5'd0);
    nop(3);

    // Async reset in the middle of a control wait
    step(1, 0, OP_JAL, 5'd0, 5'd0, 0, 5'd0);
    step(0, 0, OP_BEQ, 5'd3, 5'd3, 1, 5'd3);
    step(0, 0, OP_BEQ, 5'd3, 5'd3, 1, 5'd3);
    nop(1);

    // Two branches: saturates the 2-bit ctrl counter
    step(1, 0, OP_BEQ, 5'd0, 5'd0, 0, 5'd0);
    nop(2);
    step(1, 0, OP_BNE, 5'd0, 5'd0, 0, 5'd0);
    nop(3);

    // Randomized traffic with small register range to provoke hazards
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 9) == 0),
           ops[$urandom_range(0, 7)],
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)));
    end
    nop(2);

    @(negedge clk); #1;
    check("queue_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_sched.md
Name: pipe_hazard_sched

Overview:
- Sequential hazard scheduler for the 5-stage MIPS pipeline.
- Owns the PC and IF/ID write enables and the IF/ID and ID/EX bubble-insert controls.
- Handles two hazard types:
  - Load-use data hazards: 1-cycle stall.
  - Branch/jump control hazards: counted multi-cycle fetch block.
- Sits between the decode stage and the pipeline registers, replacing ad-hoc combinational stall/NOP logic with a single FSM plus counters.

Parameters:
BR_BUBBLES, 3, number of bubble cycles inserted after a branch/jump leaves ID (1..7)
CNT_W, 16, width of the saturating statistics counters

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
freeze  input  1  external hold (e.g. memory not ready); 1 = hold whole front end
op_d  input  6  opcode of instruction in ID
rs_d  input  5  rs field in ID
rt_d  input  5  rt field in ID
ex_memread  input  1  instruction in EX is a load
ex_rt  input  5  destination rt of instruction in EX
pc_we  output  1  PC write enable
if_id_we  output  1  IF/ID register write enable
if_id_flush  output  1  1 = IF/ID loads all-zero NOP at next edge
id_ex_flush  output  1  1 = ID/EX loads all-zero NOP at next edge
stall_data_n  output  1  0 = data-hazard stall this cycle (legacy polarity)
stall_ctrl_n  output  1  0 = control-hazard stall this cycle (legacy polarity)
busy  output  1  1 when state != RUN
data_stalls  output  CNT_W  count of load-use stall cycles, saturating
ctrl_bubbles  output  CNT_W  count of control bubble cycles, saturating

Behaviour:
- Reset: clk and reset only; reset async, active-low.
  - While reset=0: state=RUN, cnt=0, both stat counters=0.
  - Outputs are forced regardless of inputs: pc_we=1, if_id_we=1, flushes=0, stall_*_n=1, busy=0.
  - Reset mid-wait aborts the wait immediately; no pending bubble survives.
- Decode terms:
  - br_d: op_d in {000100 beq, 000101 bne, 000010 j, 000011 jal}.
  - uses_rt: op_d in {000000, 000100, 000101, 101011}.
  - lu_hz: ex_memread & ex_rt!=0 & (ex_rt==rs_d | (uses_rt & ex_rt==rt_d)).
- States: RUN, LU_STALL, CTRL_WAIT. cnt is 3 bits.
- Priority in RUN: freeze > lu_hz > br_d > normal.
- freeze=1 (any state):
  - pc_we=0, if_id_we=0, no flushes.
  - state, cnt and stat counters hold.
- RUN, lu_hz:
  - pc_we=0, if_id_we=0, id_ex_flush=1, stall_data_n=0.
  - data_stalls+1; next=LU_STALL.
  - A branch colliding with a load-use is held in ID and handled after the stall.
- RUN, br_d, !lu_hz:
  - pc_we=0, if_id_flush=1; the branch advances to EX normally (id_ex_flush=0).
  - stall_ctrl_n=0; ctrl_bubbles+1.
  - If BR_BUBBLES==1: pc_we=1 instead and next=RUN.
  - Otherwise next=CTRL_WAIT, cnt=BR_BUBBLES-2.
- RUN, otherwise: all enables 1, no flushes.
- LU_STALL:
  - Outputs normal; re-evaluates hazards exactly as RUN in the same cycle, so back-to-back stalls are possible.
  - Next state follows RUN rules.
- CTRL_WAIT:
  - if_id_flush=1, stall_ctrl_n=0, busy=1, ctrl_bubbles+1.
  - lu_hz and br_d are ignored (ID holds a NOP).
  - cnt!=0: pc_we=0, cnt-1.
  - cnt==0: pc_we=1 (PC takes resolved target), next=RUN.
  - Total bubbles per branch = BR_BUBBLES; PC is redirected exactly once.
- Outputs are combinational from state, cnt and current inputs; state and counters are registered.
- Counters saturate at all-ones and never wrap.

Test Plan:
- Reset: reset=0 with op_d=000100, ex_memread=1 -> pc_we=1, if_id_we=1, flushes 0, counters 0. Release reset: first edge acts on the inputs.
- Load-use: ex_memread=1, ex_rt=8, op_d=000000, rt_d=8 -> exactly one cycle of pc_we=0, id_ex_flush=1, stall_data_n=0; data_stalls=1. With ex_rt=0 -> no stall.
- Branch (BR_BUBBLES=3): op_d=000101 in RUN -> if_id_flush=1 for 3 consecutive cycles; pc_we=0,0,1; busy=1 in cycles 2-3; ctrl_bubbles=3; back in RUN.
- Collision: beq in ID with rs_d=ex_rt=5 and ex_memread=1 -> 1 data stall first, then 3 control bubbles; data_stalls=1, ctrl_bubbles=3.
- Freeze: assert freeze for 2 cycles during CTRL_WAIT with cnt=1 -> enables 0, cnt and counters hold; after release, the remaining 2 bubbles complete.
- Async reset mid-CTRL_WAIT (reset low between edges) -> outputs return to reset values immediately; state=RUN after release; saturation check with CNT_W=2 -> ctrl_bubbles stops at 3.
